// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS trace capture block: sampling modes and record sizing.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'd0,
        MODE_GROW     = 2'd1,
        MODE_CHANGE   = 2'd2,
        MODE_SINGLE   = 2'd3
    } trace_mode_e;

    // One stored record is {timestamp, channels}.
    function automatic int unsigned rec_width(input int unsigned num_ch,
                                              input int unsigned data_w,
                                              input int unsigned cnt_w);
        return num_ch * data_w + cnt_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; occupancy drives full/empty.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mips_trace_capture.sv
// Trace buffer for the multicycle MIPS core: scheduled sampling of core registers with
// cycle timestamps into a FIFO drained over a valid/ready port.
module mips_trace_capture
    import mips_trace_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       EN,
    input  logic                       CLEAR,
    input  logic [1:0]                 MODE,
    input  logic [CNT_W-1:0]           INTERVAL,
    input  logic [CNT_W-1:0]           STEP,
    input  logic [NUM_CH*DATA_W-1:0]   CH_IN,
    output logic                       RD_VALID,
    input  logic                       RD_READY,
    output logic [NUM_CH*DATA_W-1:0]   RD_DATA,
    output logic [CNT_W-1:0]           RD_TIME,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVERFLOW,
    output logic                       DONE
);

    localparam int unsigned REC_W = rec_width(NUM_CH, DATA_W, CNT_W);
    localparam int unsigned CH_W  = NUM_CH * DATA_W;

    trace_mode_e        mode;
    logic [CNT_W-1:0]   ts_q;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   interval_eff;
    logic [CNT_W-1:0]   next_gap;
    logic [CNT_W:0]     gap_sum;
    logic [CNT_W-1:0]   gap_grow;
    logic [DATA_W-1:0]  prev0_q;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               sample;
    logic               pop_ok;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REC_W-1:0]   wr_rec;
    logic [REC_W-1:0]   rd_rec;

    assign mode         = trace_mode_e'(MODE);
    assign interval_eff = (INTERVAL == '0) ? CNT_W'(1) : INTERVAL;
    assign gap_sum      = {1'b0, gap_q} + {1'b0, STEP};
    assign gap_grow     = gap_sum[CNT_W] ? '1 : gap_sum[CNT_W-1:0];

    always_comb begin
        sample   = 1'b0;
        wait_d   = wait_q;
        gap_d    = gap_q;
        done_d   = done_q;
        next_gap = gap_q;
        if (CLEAR || !EN) begin
            wait_d = interval_eff - CNT_W'(1);
            gap_d  = interval_eff;
            done_d = 1'b0;
        end else begin
            unique case (mode)
                MODE_CHANGE: begin
                    sample = (CH_IN[DATA_W-1:0] != prev0_q);
                end
                MODE_PERIODIC, MODE_GROW, MODE_SINGLE: begin
                    if (wait_q == '0) begin
                        next_gap = (mode == MODE_GROW) ? gap_grow : gap_q;
                        gap_d    = next_gap;
                        wait_d   = next_gap - CNT_W'(1);
                        // Once the single shot is taken the schedule keeps running silently.
                        sample   = !((mode == MODE_SINGLE) && done_q);
                        if (mode == MODE_SINGLE) begin
                            done_d = 1'b1;
                        end
                    end else begin
                        wait_d = wait_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign pop_ok = RD_READY && !fifo_empty;

    always_comb begin
        ovf_d = ovf_q;
        if (CLEAR) begin
            ovf_d = 1'b0;
        end else if (sample && fifo_full && !pop_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ts_q    <= '0;
            wait_q  <= '0;
            gap_q   <= CNT_W'(1);
            prev0_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_q + CNT_W'(1);
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            prev0_q <= CH_IN[DATA_W-1:0];
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_rec = {ts_q, CH_IN};

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .clear (CLEAR),
        .push  (sample),
        .pop   (RD_READY),
        .wdata (wr_rec),
        .rdata (rd_rec),
        .count (COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign RD_VALID = !fifo_empty;
    assign RD_DATA  = rd_rec[CH_W-1:0];
    assign RD_TIME  = rd_rec[REC_W-1 -: CNT_W];
    assign OVERFLOW = ovf_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_mips_trace_capture.sv
// Directed self-checking bench for mips_trace_capture: each scheduling mode, FIFO
// overflow with simultaneous pop, CLEAR and asynchronous reset.
module tb_mips_trace_capture;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic                     CLK = 1'b0;
    logic                     RESET = 1'b0;
    logic                     EN = 1'b0;
    logic                     CLEAR = 1'b0;
    logic [1:0]               MODE = 2'd0;
    logic [CNT_W-1:0]         INTERVAL = 16'd1;
    logic [CNT_W-1:0]         STEP = 16'd0;
    logic [NUM_CH*DATA_W-1:0] CH_IN = '0;
    logic                     RD_VALID;
    logic                     RD_READY = 1'b0;
    logic [NUM_CH*DATA_W-1:0] RD_DATA;
    logic [CNT_W-1:0]         RD_TIME;
    logic [$clog2(DEPTH):0]   COUNT;
    logic                     OVERFLOW;
    logic                     DONE;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ts_model;
    logic [15:0] got_ts[$];
    logic [31:0] got_ch0[$];

    mips_trace_capture #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .CLEAR    (CLEAR),
        .MODE     (MODE),
        .INTERVAL (INTERVAL),
        .STEP     (STEP),
        .CH_IN    (CH_IN),
        .RD_VALID (RD_VALID),
        .RD_READY (RD_READY),
        .RD_DATA  (RD_DATA),
        .RD_TIME  (RD_TIME),
        .COUNT    (COUNT),
        .OVERFLOW (OVERFLOW),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    // Expected timestamp counter value for the cycle ending at the next rising edge.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) ts_model <= 0;
        else        ts_model <= ts_model + 1;
    end

    // Called at a falling edge; logs the head if it will be popped at the coming rising edge.
    task automatic tick();
        if (RD_VALID && RD_READY) begin
            got_ts.push_back(RD_TIME);
            got_ch0.push_back(RD_DATA[31:0]);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_log();
        got_ts.delete();
        got_ch0.delete();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (RD_VALID !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", RD_VALID);
        end
        checks++;
        if (COUNT !== 5'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", COUNT);
        end
        checks++;
        if (OVERFLOW !== 1'b0 || DONE !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ovf=%b done=%b want 0 0", OVERFLOW, DONE);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_periodic();
        int unsigned en_ts;
        MODE = 2'd0; INTERVAL = 16'd10; EN = 1'b0; RD_READY = 1'b1;
        tick();
        clear_log();
        EN = 1'b1; en_ts = ts_model;
        repeat (35) tick();
        EN = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_ts.size() != 3) begin
            errors++; $display("FAIL periodic_records: got %0d want 3", got_ts.size());
        end
        for (int i = 0; i < 3 && i < got_ts.size(); i++) begin
            checks++;
            if (got_ts[i] !== 16'(en_ts + 9 + 10 * i)) begin
                errors++;
                $display("FAIL periodic_ts[%0d]: got %0d want %0d", i, got_ts[i],
                         16'(en_ts + 9 + 10 * i));
            end
        end
        checks++;
        if (OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL periodic_ovf: got %b want 0", OVERFLOW);
        end
    endtask

    task automatic test_grow();
        int unsigned en_ts;
        int offs[4] = '{7, 23, 47, 79};
        MODE = 2'd1; INTERVAL = 16'd8; STEP = 16'd8; EN = 1'b0; RD_READY = 1'b1;
        tick();
        clear_log();
        EN = 1'b1; en_ts = ts_model;
        repeat (84) tick();
        EN = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_ts.size() != 4) begin
            errors++; $display("FAIL grow_records: got %0d want 4", got_ts.size());
        end
        for (int i = 0; i < 4 && i < got_ts.size(); i++) begin
            checks++;
            if (got_ts[i] !== 16'(en_ts + offs[i])) begin
                errors++;
                $display("FAIL grow_ts[%0d]: got %0d want %0d", i, got_ts[i],
                         16'(en_ts + offs[i]));
            end
        end
    endtask

    task automatic test_change();
        logic [31:0] vals[5] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        logic [31:0] want[2] = '{32'h4, 32'h8};
        MODE = 2'd2; EN = 1'b0; RD_READY = 1'b1; CH_IN = '0;
        tick();
        clear_log();
        EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            CH_IN[31:0] = vals[i];
            tick();
        end
        repeat (3) tick();
        EN = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_ch0.size() != 2) begin
            errors++; $display("FAIL change_records: got %0d want 2", got_ch0.size());
        end
        for (int i = 0; i < 2 && i < got_ch0.size(); i++) begin
            checks++;
            if (got_ch0[i] !== want[i]) begin
                errors++;
                $display("FAIL change_ch0[%0d]: got %h want %h", i, got_ch0[i], want[i]);
            end
        end
    endtask

    task automatic test_single();
        int unsigned en_ts;
        MODE = 2'd3; INTERVAL = 16'd5; EN = 1'b0; RD_READY = 1'b1;
        tick();
        clear_log();
        EN = 1'b1; en_ts = ts_model;
        repeat (20) tick();
        checks++;
        if (got_ts.size() != 1 || (got_ts.size() == 1 && got_ts[0] !== 16'(en_ts + 4))) begin
            errors++;
            $display("FAIL single_first: got %0d records (first ts %0d) want 1 at %0d",
                     got_ts.size(), (got_ts.size() > 0) ? got_ts[0] : 16'd0, 16'(en_ts + 4));
        end
        checks++;
        if (DONE !== 1'b1) begin
            errors++; $display("FAIL single_done: got %b want 1", DONE);
        end
        EN = 1'b0;
        tick();
        checks++;
        if (DONE !== 1'b0) begin
            errors++; $display("FAIL single_done_clr: got %b want 0", DONE);
        end
        clear_log();
        EN = 1'b1; en_ts = ts_model;
        repeat (10) tick();
        checks++;
        if (got_ts.size() != 1 || (got_ts.size() == 1 && got_ts[0] !== 16'(en_ts + 4))) begin
            errors++;
            $display("FAIL single_rearm: got %0d records (first ts %0d) want 1 at %0d",
                     got_ts.size(), (got_ts.size() > 0) ? got_ts[0] : 16'd0, 16'(en_ts + 4));
        end
        checks++;
        if (DONE !== 1'b1) begin
            errors++; $display("FAIL single_done2: got %b want 1", DONE);
        end
        EN = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        int unsigned en_ts;
        MODE = 2'd0; INTERVAL = 16'd1; EN = 1'b0; RD_READY = 1'b0;
        tick();
        EN = 1'b1; en_ts = ts_model;
        for (int k = 1; k <= 16; k++) begin
            CH_IN = {32'(300 + k), 32'd0, 32'd0, 32'(k)};
            tick();
        end
        checks++;
        if (COUNT !== 5'd16 || OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL ovf_fill: got count=%0d ovf=%b want 16 0", COUNT, OVERFLOW);
        end
        CH_IN = {32'd317, 32'd0, 32'd0, 32'd17};
        tick();
        checks++;
        if (COUNT !== 5'd16 || OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL ovf_drop: got count=%0d ovf=%b want 16 1", COUNT, OVERFLOW);
        end
        RD_READY = 1'b1;
        CH_IN = {32'd318, 32'd0, 32'd0, 32'd18};
        tick();
        RD_READY = 1'b0;
        EN = 1'b0;
        checks++;
        if (COUNT !== 5'd16) begin
            errors++; $display("FAIL ovf_pushpop_count: got %0d want 16", COUNT);
        end
        checks++;
        if (RD_DATA[31:0] !== 32'd2 || RD_DATA[127:96] !== 32'd302) begin
            errors++;
            $display("FAIL ovf_head_data: got ch0=%0d ch3=%0d want 2 302",
                     RD_DATA[31:0], RD_DATA[127:96]);
        end
        checks++;
        if (RD_TIME !== 16'(en_ts + 1)) begin
            errors++; $display("FAIL ovf_head_ts: got %0d want %0d", RD_TIME, 16'(en_ts + 1));
        end
    endtask

    task automatic test_clear_reset();
        RD_READY = 1'b1;
        repeat (13) tick();
        RD_READY = 1'b0;
        checks++;
        if (COUNT !== 5'd3 || OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL clr_pre: got count=%0d ovf=%b want 3 1", COUNT, OVERFLOW);
        end
        EN = 1'b1; CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        checks++;
        if (COUNT !== 5'd0 || OVERFLOW !== 1'b0 || RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL clr_post: got count=%0d ovf=%b valid=%b want 0 0 0",
                     COUNT, OVERFLOW, RD_VALID);
        end
        repeat (2) tick();
        checks++;
        if (COUNT !== 5'd2) begin
            errors++; $display("FAIL clr_refill: got %0d want 2", COUNT);
        end
        #2 RESET = 1'b0;
        #1;
        checks++;
        if (RD_VALID !== 1'b0 || COUNT !== 5'd0) begin
            errors++; $display("FAIL async_reset: got valid=%b count=%0d want 0 0", RD_VALID, COUNT);
        end
        @(negedge CLK);
        RESET = 1'b1; EN = 1'b0; MODE = 2'd0; INTERVAL = 16'd3; RD_READY = 1'b0;
        tick();
        EN = 1'b1;
        repeat (3) tick();
        checks++;
        if (RD_VALID !== 1'b1 || RD_TIME !== 16'd3) begin
            errors++; $display("FAIL reset_ts: got valid=%b ts=%0d want 1 3", RD_VALID, RD_TIME);
        end
        EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_grow();
        test_change();
        test_single();
        test_overflow();
        test_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
